// File: rtl/seq_div_nm.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Optional divide-by-zero short-cut and flag enabled by SEQDIV_DBZ_EN.
module seq_div_nm #(
    parameter int N = 5,
    parameter int M = 18
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [N-1:0] B,
    output logic         ready,
    output logic [M-1:0] Q,
    output logic [N-1:0] R
`ifdef SEQDIV_DBZ_EN
    ,
    output logic         dbz
`endif
);

    localparam int CW = $clog2(M + 1);
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [M-1:0]   quo;
    logic [N-1:0]   rem;
    logic [N-1:0]   div;
    logic [N:0]     trial;
    logic [N-1:0]   diff;
    logic [N-1:0]   rem_nx;
    logic           qbit;
    logic           done;
    logic           dbz_r;

    // Partial remainder stays below the divisor, so the low N bits of
    // the difference are exact whenever the subtraction is kept.
    always_comb begin
        trial  = {rem, quo[M-1]};
        diff   = trial[N-1:0] - div;
        qbit   = (trial >= {1'b0, div});
        rem_nx = qbit ? diff : trial[N-1:0];
    end

`ifdef SEQDIV_DBZ_EN
    assign done = (cnt == LAST) || dbz_r;
    assign dbz  = dbz_r;
`else
    assign done = (cnt == LAST);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quo   <= '0;
            rem   <= '0;
            div   <= '0;
            cnt   <= '0;
            dbz_r <= 1'b0;
        end else if (state == IDLE && start) begin
            div <= B;
            cnt <= '0;
            rem <= '0;
`ifdef SEQDIV_DBZ_EN
            // Zero divisor skips the iterations entirely.
            if (B == '0) begin
                quo   <= '1;
                dbz_r <= 1'b1;
            end else begin
                quo   <= A;
                dbz_r <= 1'b0;
            end
`else
            quo <= A;
`endif
        end else if (state == BUSY && !dbz_r) begin
            quo <= {quo[M-2:0], qbit};
            rem <= rem_nx;
            cnt <= cnt + CW'(1);
        end
    end

    assign Q = quo;
    assign R = rem;

endmodule

// File: tb/tb_seq_div_nm.sv
// Self-checking bench for seq_div_nm: vector table, scoreboard queue,
// plus hand-written reset and ignored-start sequences.
module tb_seq_div_nm;

    localparam int N = 5;
    localparam int M = 18;

    typedef struct {
        logic [M-1:0] a;
        logic [N-1:0] b;
        logic [M-1:0] q;
        logic [N-1:0] r;
        int           lat;
        logic         dz;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [M-1:0] A;
    logic [N-1:0] B;
    logic         ready;
    logic [M-1:0] Q;
    logic [N-1:0] R;
`ifdef SEQDIV_DBZ_EN
    logic         dbz;
`endif

    int   total;
    int   passed;
    vec_t exp_q[$];
    vec_t tbl[9];

    seq_div_nm #(.N(N), .M(M)) dut (
        .clock (clk),
        .reset (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .ready (ready),
        .Q     (Q),
        .R     (R)
`ifdef SEQDIV_DBZ_EN
        ,
        .dbz   (dbz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic launch(input vec_t v);
        int w;
        w = 0;
        while (!ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!ready) chk("launch_wait", 64'(ready), 64'd1);
        A     = v.a;
        B     = v.b;
        start = 1'b1;
        exp_q.push_back(v);
    endtask

    // Counts ready-low cycles after the start edge, then scores the result.
    task automatic collect(input bit poke);
        int   cyc;
        vec_t e;
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            if (!ready) cyc++;
            if (poke && cyc == 5) begin
                start = 1'b1;
                A     = 18'd50;
                B     = 5'd3;
            end
        end while (!ready && cyc < 100);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("latency", 64'(cyc), 64'(e.lat));
            chk("Q", 64'(Q), 64'(e.q));
            chk("R", 64'(R), 64'(e.r));
`ifdef SEQDIV_DBZ_EN
            chk("dbz", 64'(dbz), 64'(e.dz));
`endif
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total  = 0;
        passed = 0;
        tbl[0] = '{18'd100, 5'd7, 18'd14, 5'd2, M, 1'b0};
        tbl[1] = '{18'd262143, 5'd31, 18'd8456, 5'd7, M, 1'b0};
        tbl[2] = '{18'd5, 5'd9, 18'd0, 5'd5, M, 1'b0};
        tbl[3] = '{18'd30, 5'd31, 18'd0, 5'd30, M, 1'b0};
        tbl[4] = '{18'd262143, 5'd1, 18'd262143, 5'd0, M, 1'b0};
        tbl[5] = '{18'd0, 5'd3, 18'd0, 5'd0, M, 1'b0};
        tbl[6] = '{18'd1000, 5'd10, 18'd100, 5'd0, M, 1'b0};
`ifdef SEQDIV_DBZ_EN
        tbl[7] = '{18'd20, 5'd0, 18'd262143, 5'd0, 1, 1'b1};
`else
        tbl[7] = '{18'd20, 5'd0, 18'd262143, 5'd20, M, 1'b0};
`endif
        tbl[8] = '{18'd20, 5'd9, 18'd2, 5'd2, M, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_Q", 64'(Q), 64'd0);
        chk("rst_R", 64'(R), 64'd0);

        // Start held during reset is ignored, accepted right after release.
        start = 1'b1;
        A     = 18'd100;
        B     = 5'd7;
        @(negedge clk);
        chk("start_in_reset", 64'(ready), 64'd1);
        rst_n = 1'b1;
        exp_q.push_back(tbl[0]);
        collect(1'b0);

        // Back-to-back table, each issued on the first ready cycle.
        for (int i = 0; i < 9; i++) begin
            launch(tbl[i]);
            collect(1'b0);
        end

        // Second start and input changes mid-operation must be ignored.
        launch(tbl[0]);
        collect(1'b1);

        // Reset at BUSY cycle 9 aborts the division.
        launch(tbl[0]);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_before_abort", 64'(ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_Q", 64'(Q), 64'd0);
        chk("abort_R", 64'(R), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(tbl[8]);
        collect(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_div_nm.md
SEQ_DIV_NM -- requirements
Module: seq_div_nm

Interface
REQ-001 SHALL have parameter N, default 5, divisor width in bits (N >= 2).
REQ-002 SHALL have parameter M, default 18, dividend width in bits (M >= N).
REQ-003 SHALL have port clock, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse requesting a division.
REQ-006 SHALL have port ready, output, 1, high when idle and the result is valid.
REQ-007 SHALL have port A, input, M, unsigned dividend.
REQ-008 SHALL have port B, input, N, unsigned divisor.
REQ-009 SHALL have port Q, output, M, quotient floor(A/B).
REQ-010 SHALL have port R, output, N, remainder A mod B.
REQ-011 SHALL have port dbz, output, 1, divide-by-zero flag, present only with SEQDIV_DBZ_EN.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (ready=1) and BUSY (ready=0).
REQ-013 SHALL, in IDLE, sample start=1 on a rising edge, latch A and B, clear the iteration counter and enter BUSY.
REQ-014 SHALL ignore changes on A and B after the start edge until the next accepted start.
REQ-015 SHALL ignore start while in BUSY; no restart, no queuing.
REQ-016 SHALL use restoring shift-subtract division with an (N+1)-bit partial remainder and produce one quotient bit per clock, MSB first.
REQ-017 SHALL complete in exactly M BUSY cycles: start sampled at edge k gives ready=1 after edge k+M.
REQ-018 SHALL hold Q and R stable, with R < B, from the rising edge of ready until the next accepted start.
REQ-019 SHALL leave Q and R unspecified while ready=0; the bench checks them only when ready=1.
REQ-020 SHALL accept a new start in the first cycle ready=1 (back-to-back operation, M+1 cycles per division).
REQ-021 SHALL give, for A < B, Q=0 and R=A[N-1:0].
REQ-022 SHALL give, for B=0 without SEQDIV_DBZ_EN, the natural algorithm result: Q=all ones, R=A[N-1:0], latency M.
REQ-023 SHALL use an iteration counter of width clog2(M+1) that does not wrap during an operation.

Reset
REQ-024 SHALL, on reset=0, asynchronously force IDLE, ready=1, Q=0, R=0, counter=0 and dbz=0 where present.
REQ-025 SHALL let reset asserted mid-operation abort the division with no result delivered.
REQ-026 SHALL ignore start while reset=0, and accept it on the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL gate the divide-by-zero feature with macro SEQDIV_DBZ_EN.
REQ-028 SHALL, with SEQDIV_DBZ_EN defined and B=0 at start, skip BUSY iterations, set Q=all ones, R=0, dbz=1, and hold ready=0 for exactly one cycle.
REQ-029 SHALL, with SEQDIV_DBZ_EN defined, clear dbz on the next accepted start with B != 0.
REQ-030 SHALL, without SEQDIV_DBZ_EN, omit the dbz port and handle B=0 per REQ-022.

Verification
REQ-031 SHALL cover: N=5, M=18, reset, A=100, B=7, start pulse -> ready low M=18 cycles, then Q=14, R=2.
REQ-032 SHALL cover: A=262143, B=31 -> Q=8456, R=7; A=5, B=9 -> Q=0, R=5, issued back-to-back on the first ready cycle.
REQ-033 SHALL cover: start at cycle 0 with A=100, B=7; start again at cycle 5 with A=50, B=3 -> second start ignored, result Q=14, R=2 at cycle 18.
REQ-034 SHALL cover: reset pulled low at BUSY cycle 9 -> ready=1, Q=0, R=0 immediately; next start with A=20, B=9 -> Q=2, R=2.
REQ-035 SHALL cover: A=20, B=0 -> with SEQDIV_DBZ_EN: ready low 1 cycle, dbz=1, Q=262143, R=0; without it: ready low 18 cycles, Q=262143, R=20.
